// File: rtl/pong_match_timer.sv
// Countdown match timer with one-second prescaler, pause, auto-reload and expiry pulse.
// A sequential divider converts the remaining seconds into registered MM:SS BCD digits.
module pong_match_timer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned TIME_W   = 12
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [TIME_W-1:0] max_time,
  input  logic              start,
  input  logic              pause,
  input  logic              auto_reload,
  output logic [TIME_W-1:0] remaining,
  output logic              running,
  output logic              time_out,
  output logic [3:0]        min_t,
  output logic [3:0]        min_o,
  output logic [3:0]        sec_t,
  output logic [3:0]        sec_o,
  output logic              digits_valid
);

  localparam int unsigned     PreW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [PreW-1:0]   presc_q, presc_d;
  logic              time_out_q, time_out_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    time_out_d  = 1'b0;
    if (start) begin
      remaining_d = max_time;
      presc_d     = '0;
      if (max_time == '0) begin
        time_out_d = 1'b1;
        state_d    = StDone;
      end else begin
        state_d = StRun;
      end
    end else begin
      case (state_q)
        StRun, StPause: begin
          if (pause) begin
            state_d = StPause;
          end else begin
            // Releasing pause counts on the same edge, so a pause costs exactly its length.
            state_d = StRun;
            if (presc_q == PreLast) begin
              presc_d = '0;
              if (remaining_q > TIME_W'(1)) begin
                remaining_d = remaining_q - TIME_W'(1);
              end else begin
                time_out_d = 1'b1;
                if (auto_reload && (max_time != '0)) begin
                  remaining_d = max_time;
                end else begin
                  remaining_d = '0;
                  state_d     = StDone;
                end
              end
            end else begin
              presc_d = presc_q + PreW'(1);
            end
          end
        end
        StDone:  remaining_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      presc_q     <= '0;
      time_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      time_out_q  <= time_out_d;
    end
  end

  // Digit converter: one subtraction per cycle, digits committed together at the end.
  logic [TIME_W-1:0] last_q, last_d;
  logic [11:0]       work_q, work_d;
  logic [6:0]        mins_q, mins_d;
  logic [2:0]        st_cnt_q, st_cnt_d, mt_cnt_q, mt_cnt_d;
  logic              busy_q, busy_d, valid_q, valid_d;
  logic [3:0]        min_t_q, min_t_d, min_o_q, min_o_d, sec_t_q, sec_t_d, sec_o_q, sec_o_d;

  always_comb begin
    last_d   = last_q;
    work_d   = work_q;
    mins_d   = mins_q;
    st_cnt_d = st_cnt_q;
    mt_cnt_d = mt_cnt_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    min_t_d  = min_t_q;
    min_o_d  = min_o_q;
    sec_t_d  = sec_t_q;
    sec_o_d  = sec_o_q;
    if (remaining_q != last_q) begin
      // New value (possibly mid-conversion): restart from a fresh snapshot.
      last_d   = remaining_q;
      work_d   = 12'(remaining_q);
      mins_d   = '0;
      st_cnt_d = '0;
      mt_cnt_d = '0;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
    end else if (busy_q) begin
      if (work_q >= 12'd60) begin
        work_d = work_q - 12'd60;
        mins_d = mins_q + 7'd1;
      end else if (work_q >= 12'd10) begin
        work_d   = work_q - 12'd10;
        st_cnt_d = st_cnt_q + 3'd1;
      end else if (mins_q >= 7'd10) begin
        mins_d   = mins_q - 7'd10;
        mt_cnt_d = mt_cnt_q + 3'd1;
      end else begin
        min_t_d = {1'b0, mt_cnt_q};
        min_o_d = mins_q[3:0];
        sec_t_d = {1'b0, st_cnt_q};
        sec_o_d = work_q[3:0];
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      last_q   <= '0;
      work_q   <= '0;
      mins_q   <= '0;
      st_cnt_q <= '0;
      mt_cnt_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b1;
      min_t_q  <= '0;
      min_o_q  <= '0;
      sec_t_q  <= '0;
      sec_o_q  <= '0;
    end else begin
      last_q   <= last_d;
      work_q   <= work_d;
      mins_q   <= mins_d;
      st_cnt_q <= st_cnt_d;
      mt_cnt_q <= mt_cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      min_t_q  <= min_t_d;
      min_o_q  <= min_o_d;
      sec_t_q  <= sec_t_d;
      sec_o_q  <= sec_o_d;
    end
  end

  assign remaining    = remaining_q;
  assign running      = (state_q == StRun);
  assign time_out     = time_out_q;
  assign min_t        = min_t_q;
  assign min_o        = min_o_q;
  assign sec_t        = sec_t_q;
  assign sec_o        = sec_o_q;
  assign digits_valid = valid_q;

endmodule

// File: tb/tb_pong_match_timer.sv
// Scoreboard bench for pong_match_timer: expectations are queued with their due cycle when
// stimulus is driven and compared on the falling edge of that cycle.
module tb_pong_match_timer;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned TimeW   = 12;

  localparam int SigRem   = 0;
  localparam int SigRun   = 1;
  localparam int SigTo    = 2;
  localparam int SigDig   = 3;
  localparam int SigValid = 4;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic [TimeW-1:0] max_time = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             auto_reload = 1'b0;
  logic [TimeW-1:0] remaining;
  logic             running;
  logic             time_out;
  logic [3:0]       min_t, min_o, sec_t, sec_o;
  logic             digits_valid;

  pong_match_timer #(
    .TICK_DIV(TickDiv),
    .TIME_W  (TimeW)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .max_time    (max_time),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .remaining   (remaining),
    .running     (running),
    .time_out    (time_out),
    .min_t       (min_t),
    .min_o       (min_o),
    .sec_t       (sec_t),
    .sec_o       (sec_o),
    .digits_valid(digits_valid)
  );

  always #5 clk_in = ~clk_in;

  // cyc equals the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t pend[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SigRem:  return 32'(remaining);
      SigRun:  return 32'(running);
      SigTo:   return 32'(time_out);
      SigDig:  return {16'h0, min_t, min_o, sec_t, sec_o};
      default: return 32'(digits_valid);
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input logic [31:0] val, input string tag);
    exp_t e;
    e.at  = at;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk_in) begin
    pend.delete();
    foreach (sb[i]) begin
      if (sb[i].at <= cyc) check_val(sb[i].tag, observe(sb[i].sig), sb[i].val);
      else pend.push_back(sb[i]);
    end
    sb = pend;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Start is sampled on the next edge; returns just after that edge.
  task automatic do_start(input logic [TimeW-1:0] mt);
    max_time = mt;
    start    = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  int t;

  initial begin
    // Reset values
    expect_at(2, SigRem, 0, "rst_rem");
    expect_at(2, SigRun, 0, "rst_run");
    expect_at(2, SigTo, 0, "rst_to");
    expect_at(2, SigDig, 0, "rst_dig");
    expect_at(2, SigValid, 1, "rst_valid");
    step(3);
    reset = 1'b0;
    step(1);

    // One-shot countdown of 3 s
    auto_reload = 1'b0;
    t = cyc + 1;
    expect_at(t, SigRem, 3, "os_rem3");
    expect_at(t, SigRun, 1, "os_run");
    expect_at(t, SigTo, 0, "os_to_lo");
    expect_at(t + 3, SigRem, 3, "os_rem3_hold");
    expect_at(t + 4, SigRem, 2, "os_rem2");
    expect_at(t + 8, SigRem, 1, "os_rem1");
    expect_at(t + 11, SigTo, 0, "os_to_early");
    expect_at(t + 12, SigRem, 0, "os_rem0");
    expect_at(t + 12, SigTo, 1, "os_to_pulse");
    expect_at(t + 12, SigRun, 0, "os_done");
    expect_at(t + 13, SigTo, 0, "os_to_once");
    do_start(3);
    step(14);

    // Auto-reload, max_time changed mid-period
    auto_reload = 1'b1;
    t = cyc + 1;
    expect_at(t, SigRem, 2, "ar_rem2");
    expect_at(t + 4, SigRem, 1, "ar_rem1");
    expect_at(t + 7, SigTo, 0, "ar_to_lo");
    expect_at(t + 8, SigRem, 2, "ar_reload2");
    expect_at(t + 8, SigTo, 1, "ar_to1");
    expect_at(t + 9, SigTo, 0, "ar_to1_end");
    expect_at(t + 12, SigRem, 1, "ar_rem1b");
    expect_at(t + 16, SigRem, 5, "ar_reload5");
    expect_at(t + 16, SigTo, 1, "ar_to2");
    expect_at(t + 17, SigTo, 0, "ar_to2_end");
    expect_at(t + 20, SigRem, 4, "ar_rem4");
    expect_at(t + 20, SigRun, 1, "ar_run");
    do_start(2);
    step(10);
    max_time = 5;
    step(12);
    auto_reload = 1'b0;

    // Pause from edge t+2 for 10 edges delays expiry by exactly 10 cycles
    t = cyc + 1;
    expect_at(t, SigRem, 3, "pz_rem3");
    expect_at(t + 5, SigRem, 3, "pz_frozen");
    expect_at(t + 5, SigRun, 0, "pz_run0");
    expect_at(t + 11, SigRem, 3, "pz_frozen_end");
    expect_at(t + 13, SigRun, 1, "pz_resumed");
    expect_at(t + 13, SigRem, 3, "pz_rem3_after");
    expect_at(t + 14, SigRem, 2, "pz_rem2");
    expect_at(t + 18, SigRem, 1, "pz_rem1");
    expect_at(t + 21, SigTo, 0, "pz_to_early");
    expect_at(t + 22, SigRem, 0, "pz_rem0");
    expect_at(t + 22, SigTo, 1, "pz_to");
    expect_at(t + 23, SigTo, 0, "pz_to_end");
    expect_at(t + 23, SigRun, 0, "pz_done");
    do_start(3);
    step(1);
    pause = 1'b1;
    step(10);
    pause = 1'b0;
    step(13);

    // Zero length: a single pulse, then DONE even with auto-reload
    auto_reload = 1'b1;
    t = cyc + 1;
    expect_at(t, SigRem, 0, "z_rem");
    expect_at(t, SigTo, 1, "z_to");
    expect_at(t, SigRun, 0, "z_run");
    expect_at(t + 1, SigTo, 0, "z_to_end");
    expect_at(t + 6, SigTo, 0, "z_no_more");
    expect_at(t + 6, SigRun, 0, "z_done");
    do_start(0);
    step(7);
    auto_reload = 1'b0;

    // Start together with pause while running: restart wins
    t = cyc + 1;
    expect_at(t, SigRem, 3, "sp_rem3");
    expect_at(t + 2, SigRem, 7, "sp_rem7");
    expect_at(t + 2, SigRun, 1, "sp_run");
    expect_at(t + 5, SigRem, 7, "sp_rem7_hold");
    expect_at(t + 6, SigRem, 6, "sp_rem6");
    do_start(3);
    step(1);
    max_time = 7;
    start    = 1'b1;
    pause    = 1'b1;
    step(1);
    start = 1'b0;
    pause = 1'b0;
    step(5);

    // Reset in the middle of a run
    t = cyc + 1;
    expect_at(t, SigRem, 0, "mr_rem");
    expect_at(t, SigRun, 0, "mr_run");
    expect_at(t, SigTo, 0, "mr_to");
    expect_at(t, SigDig, 0, "mr_dig");
    expect_at(t, SigValid, 1, "mr_valid");
    expect_at(t + 2, SigRem, 0, "mr_idle_hold");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);

    // 754 s -> 12:34 after 18 cycles, old digits held meanwhile
    pause = 1'b1;
    t = cyc + 1;
    expect_at(t, SigRem, 754, "d_rem");
    expect_at(t, SigRun, 1, "d_run");
    expect_at(t + 1, SigValid, 0, "d_valid_drop");
    expect_at(t + 1, SigDig, 0, "d_old_hold");
    expect_at(t + 17, SigValid, 0, "d_valid_lo");
    expect_at(t + 17, SigDig, 0, "d_old_hold_end");
    expect_at(t + 18, SigValid, 1, "d_valid_hi");
    expect_at(t + 18, SigDig, 32'h1234, "d_1234");
    expect_at(t + 18, SigRem, 754, "d_rem_paused");
    do_start(754);
    step(20);

    // 4095 conversion aborted by restart to 9
    t = cyc + 1;
    expect_at(t, SigRem, 4095, "ab_rem");
    expect_at(t + 19, SigValid, 0, "ab_busy");
    expect_at(t + 19, SigDig, 32'h1234, "ab_old");
    expect_at(t + 20, SigRem, 9, "ab_rem9");
    expect_at(t + 21, SigValid, 0, "ab_restart");
    expect_at(t + 21, SigDig, 32'h1234, "ab_old2");
    expect_at(t + 22, SigValid, 1, "ab_valid");
    expect_at(t + 22, SigDig, 32'h0009, "ab_0009");
    expect_at(t + 80, SigDig, 32'h0009, "ab_no_stale");
    do_start(4095);
    step(19);
    max_time = 9;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(62);

    // Full 4095 conversion -> 68:15, latency 77
    t = cyc + 1;
    expect_at(t + 76, SigValid, 0, "mx_busy");
    expect_at(t + 76, SigDig, 32'h0009, "mx_old");
    expect_at(t + 77, SigValid, 1, "mx_valid");
    expect_at(t + 77, SigDig, 32'h6815, "mx_6815");
    do_start(4095);
    step(80);
    pause = 1'b0;

    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    check_val("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
